// File: rtl/rec_play_ctrl_if.sv
// Control/status bundle between the record/play sequencer and its surroundings.
// master drives requests and the sample strobe; slave is the sequencer.
interface rec_play_ctrl_if #(parameter int ADDR_W = 16);
  logic              sample_tick;
  logic              rec_btn;
  logic              play_btn;
  logic              stop_btn;
  logic              we;
  logic [ADDR_W-1:0] waddr;
  logic [ADDR_W-1:0] raddr;
  logic              buff_sel;
  logic [1:0]        state;
  logic [ADDR_W:0]   rec_len;
  logic              full;

  modport master (
    output sample_tick, rec_btn, play_btn, stop_btn,
    input  we, waddr, raddr, buff_sel, state, rec_len, full
  );

  modport slave (
    input  sample_tick, rec_btn, play_btn, stop_btn,
    output we, waddr, raddr, buff_sel, state, rec_len, full
  );
endinterface

// File: rtl/rec_play_ctrl.sv
// Record/play sequencer for the mic sample buffer: write/read address pacing,
// recorded length and live/buffer select. `define LOOP_PLAY_EN for looping playback.
module rec_play_ctrl #(
  parameter int ADDR_W  = 16,
  parameter int MIN_LEN = 1
) (
  input logic           clk,
  input logic           rst,
  rec_play_ctrl_if.slave bus
);
  localparam logic [ADDR_W-1:0] LAST_ADDR = '1;
  localparam logic [ADDR_W:0]   DEPTH_LEN = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [ADDR_W:0]   MIN_L     = (ADDR_W+1)'(MIN_LEN);
  localparam logic [ADDR_W:0]   ONE_L     = {{ADDR_W{1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_REC  = 2'b01,
    S_PLAY = 2'b10
  } state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] waddr_q, waddr_d;
  logic [ADDR_W-1:0] raddr_q, raddr_d;
  logic [ADDR_W:0]   rec_len_q, rec_len_d;
  logic              buff_sel_q, buff_sel_d;
  logic              full_q, full_d;
  logic              rec_prev_q, play_prev_q, stop_prev_q;
  logic              rec_e, play_e, stop_e;
  logic              we;
  logic              play_end;

  assign rec_e  = bus.rec_btn  & ~rec_prev_q;
  assign play_e = bus.play_btn & ~play_prev_q;
  assign stop_e = bus.stop_btn & ~stop_prev_q;

  // A restart (rec edge not overridden by stop) suppresses the write that cycle.
  assign we       = (state_q == S_REC) & bus.sample_tick & ~(rec_e & ~stop_e);
  assign play_end = ({1'b0, raddr_q} == (rec_len_q - ONE_L));

  always_comb begin
    state_d    = state_q;
    waddr_d    = waddr_q;
    raddr_d    = raddr_q;
    rec_len_d  = rec_len_q;
    buff_sel_d = buff_sel_q;
    full_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (stop_e) begin
          state_d = S_IDLE;
        end else if (rec_e) begin
          state_d = S_REC;
          waddr_d = '0;
        end else if (play_e && (rec_len_q >= MIN_L)) begin
          state_d    = S_PLAY;
          raddr_d    = '0;
          buff_sel_d = 1'b1;
        end
      end
      S_REC: begin
        if (stop_e) begin
          state_d   = S_IDLE;
          rec_len_d = {1'b0, waddr_q} + {{ADDR_W{1'b0}}, we};
          waddr_d   = waddr_q + {{(ADDR_W-1){1'b0}}, we};
        end else if (rec_e) begin
          waddr_d = '0;
        end else if (we) begin
          waddr_d = waddr_q + 1'b1;
          if (waddr_q == LAST_ADDR) begin
            state_d   = S_IDLE;
            rec_len_d = DEPTH_LEN;
            full_d    = 1'b1;
          end
        end
      end
      S_PLAY: begin
        if (stop_e) begin
          state_d    = S_IDLE;
          raddr_d    = '0;
          buff_sel_d = 1'b0;
        end else if (rec_e) begin
          state_d    = S_REC;
          waddr_d    = '0;
          raddr_d    = '0;
          buff_sel_d = 1'b0;
        end else if (play_e) begin
          raddr_d = '0;
        end else if (bus.sample_tick) begin
          if (play_end) begin
            raddr_d = '0;
`ifndef LOOP_PLAY_EN
            state_d    = S_IDLE;
            buff_sel_d = 1'b0;
`endif
          end else begin
            raddr_d = raddr_q + 1'b1;
          end
        end
      end
      default: begin
        state_d    = S_IDLE;
        buff_sel_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      waddr_q     <= '0;
      raddr_q     <= '0;
      rec_len_q   <= '0;
      buff_sel_q  <= 1'b0;
      full_q      <= 1'b0;
      rec_prev_q  <= 1'b0;
      play_prev_q <= 1'b0;
      stop_prev_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      waddr_q     <= waddr_d;
      raddr_q     <= raddr_d;
      rec_len_q   <= rec_len_d;
      buff_sel_q  <= buff_sel_d;
      full_q      <= full_d;
      rec_prev_q  <= bus.rec_btn;
      play_prev_q <= bus.play_btn;
      stop_prev_q <= bus.stop_btn;
    end
  end

  assign bus.we       = we;
  assign bus.waddr    = waddr_q;
  assign bus.raddr    = raddr_q;
  assign bus.buff_sel = buff_sel_q;
  assign bus.state    = state_q;
  assign bus.rec_len  = rec_len_q;
  assign bus.full     = full_q;
endmodule

// File: tb/tb_rec_play_ctrl.sv
// Directed bench for rec_play_ctrl with an 8-deep buffer (ADDR_W=3).
// Playback expectations follow LOOP_PLAY_EN when it is defined.
module tb_rec_play_ctrl;
  localparam int AW = 3;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_chk  = 0;
  int   n_pass = 0;
  int   we_cnt = 0;
  int   full_cnt = 0;

  rec_play_ctrl_if #(.ADDR_W(AW)) bus ();

  rec_play_ctrl #(.ADDR_W(AW), .MIN_LEN(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (bus.we === 1'b1)   we_cnt++;
    if (bus.full === 1'b1) full_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_once();
    bus.sample_tick = 1'b1;
    cyc();
    bus.sample_tick = 1'b0;
    cyc();
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, " state"},    32'(bus.state), 0);
    chk({tag, " we"},       32'(bus.we), 0);
    chk({tag, " waddr"},    32'(bus.waddr), 0);
    chk({tag, " raddr"},    32'(bus.raddr), 0);
    chk({tag, " buff_sel"}, 32'(bus.buff_sel), 0);
    chk({tag, " rec_len"},  32'(bus.rec_len), 0);
    chk({tag, " full"},     32'(bus.full), 0);
  endtask

  initial begin
    int w0, f0;
    int n_play;
    bus.sample_tick = 1'b0;
    bus.rec_btn     = 1'b0;
    bus.play_btn    = 1'b0;
    bus.stop_btn    = 1'b0;
    repeat (2) cyc();
    rst = 1'b0;
    chk_reset_vals("reset");

    // idle with periodic ticks, plus a play request with nothing recorded
    w0 = we_cnt; f0 = full_cnt;
    bus.play_btn = 1'b1;
    repeat (3) begin
      repeat (11) cyc();
      bus.sample_tick = 1'b1;
      cyc();
      bus.sample_tick = 1'b0;
    end
    bus.play_btn = 1'b0;
    chk("idle we count", 32'(we_cnt - w0), 0);
    chk("idle full count", 32'(full_cnt - f0), 0);
    chk("idle state", 32'(bus.state), 0);
    chk("idle buff_sel", 32'(bus.buff_sel), 0);
    chk("idle rec_len", 32'(bus.rec_len), 0);

    // record 5 samples with rec held (no retrigger), then stop
    bus.rec_btn = 1'b1;
    cyc();
    chk("rec5 state", 32'(bus.state), 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      if (i == 0) chk("rec5 no tick we", 32'(bus.we), 0);
      bus.sample_tick = 1'b1;
      #1;
      chk("rec5 we", 32'(bus.we), 1);
      chk("rec5 waddr", 32'(bus.waddr), 32'(i));
      cyc();
      bus.sample_tick = 1'b0;
    end
    bus.rec_btn  = 1'b0;
    bus.stop_btn = 1'b1;
    cyc();
    bus.stop_btn = 1'b0;
    chk("rec5 stop state", 32'(bus.state), 0);
    chk("rec5 rec_len", 32'(bus.rec_len), 5);

    // play the 5 samples back
    bus.play_btn = 1'b1;
    cyc();
    bus.play_btn = 1'b0;
    chk("play5 state", 32'(bus.state), 2);
    chk("play5 buff_sel", 32'(bus.buff_sel), 1);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("play5 raddr", 32'(bus.raddr), 32'(i));
      bus.sample_tick = 1'b1;
      cyc();
      bus.sample_tick = 1'b0;
    end
    chk("play5 end raddr", 32'(bus.raddr), 0);
`ifdef LOOP_PLAY_EN
    chk("play5 loop state", 32'(bus.state), 2);
    chk("play5 loop buff_sel", 32'(bus.buff_sel), 1);
    bus.stop_btn = 1'b1;
    cyc();
    bus.stop_btn = 1'b0;
`endif
    chk("play5 end state", 32'(bus.state), 0);
    chk("play5 end buff_sel", 32'(bus.buff_sel), 0);

    // capacity: 10 ticks into an 8-deep buffer
    w0 = we_cnt; f0 = full_cnt;
    bus.rec_btn = 1'b1;
    cyc();
    bus.rec_btn = 1'b0;
    chk("full state rec", 32'(bus.state), 1);
    chk("full waddr start", 32'(bus.waddr), 0);
    for (int i = 0; i < 10; i++) begin
      bus.sample_tick = 1'b1;
      #1;
      chk("full we", 32'(bus.we), (i < 8) ? 1 : 0);
      if (i < 8) chk("full waddr", 32'(bus.waddr), 32'(i));
      cyc();
      bus.sample_tick = 1'b0;
      chk("full pulse", 32'(bus.full), (i == 7) ? 1 : 0);
      if (i == 7) chk("full state idle", 32'(bus.state), 0);
      cyc();
    end
    chk("full we count", 32'(we_cnt - w0), 8);
    chk("full pulse count", 32'(full_cnt - f0), 1);
    chk("full rec_len", 32'(bus.rec_len), 8);
    chk("full waddr wrap", 32'(bus.waddr), 0);

    // simultaneous stop+rec+play in IDLE: stop wins
    bus.stop_btn = 1'b1; bus.rec_btn = 1'b1; bus.play_btn = 1'b1;
    cyc();
    chk("all edges state", 32'(bus.state), 0);
    chk("all edges buff_sel", 32'(bus.buff_sel), 0);
    bus.stop_btn = 1'b0; bus.rec_btn = 1'b0; bus.play_btn = 1'b0;
    cyc();

    // restart inside RECORD coinciding with a tick
    bus.rec_btn = 1'b1;
    cyc();
    bus.rec_btn = 1'b0;
    tick_once();
    tick_once();
    chk("restart pre waddr", 32'(bus.waddr), 2);
    bus.rec_btn = 1'b1;
    bus.sample_tick = 1'b1;
    #1;
    chk("restart we", 32'(bus.we), 0);
    cyc();
    bus.rec_btn = 1'b0;
    bus.sample_tick = 1'b0;
    chk("restart waddr", 32'(bus.waddr), 0);
    chk("restart state", 32'(bus.state), 1);
    chk("restart rec_len kept", 32'(bus.rec_len), 8);
    bus.play_btn = 1'b1;
    cyc();
    bus.play_btn = 1'b0;
    chk("play in rec ignored", 32'(bus.state), 1);
    // stop together with a tick counts that write
    bus.stop_btn = 1'b1;
    bus.sample_tick = 1'b1;
    #1;
    chk("stop+tick we", 32'(bus.we), 1);
    cyc();
    bus.stop_btn = 1'b0;
    bus.sample_tick = 1'b0;
    chk("stop+tick state", 32'(bus.state), 0);
    chk("stop+tick rec_len", 32'(bus.rec_len), 1);
    cyc();

    // 3-sample recording, then playback
    bus.rec_btn = 1'b1;
    cyc();
    bus.rec_btn = 1'b0;
    repeat (3) tick_once();
    bus.stop_btn = 1'b1;
    cyc();
    bus.stop_btn = 1'b0;
    chk("rec3 rec_len", 32'(bus.rec_len), 3);
    bus.play_btn = 1'b1;
    cyc();
    bus.play_btn = 1'b0;
`ifdef LOOP_PLAY_EN
    n_play = 7;
`else
    n_play = 3;
`endif
    for (int i = 0; i < n_play; i++) begin
      cyc();
      chk("play3 raddr", 32'(bus.raddr), 32'(i % 3));
      chk("play3 state", 32'(bus.state), 2);
      bus.sample_tick = 1'b1;
      cyc();
      bus.sample_tick = 1'b0;
    end
`ifdef LOOP_PLAY_EN
    chk("play3 loop state", 32'(bus.state), 2);
    chk("play3 loop raddr", 32'(bus.raddr), 1);
    bus.stop_btn = 1'b1;
    cyc();
    bus.stop_btn = 1'b0;
`endif
    chk("play3 end state", 32'(bus.state), 0);

    // rec edge during PLAY starts a new recording
    bus.play_btn = 1'b1;
    cyc();
    bus.play_btn = 1'b0;
    tick_once();
    chk("play->rec raddr", 32'(bus.raddr), 1);
    bus.rec_btn = 1'b1;
    cyc();
    bus.rec_btn = 1'b0;
    chk("play->rec state", 32'(bus.state), 1);
    chk("play->rec buff_sel", 32'(bus.buff_sel), 0);
    chk("play->rec waddr", 32'(bus.waddr), 0);
    tick_once();
    tick_once();
    bus.stop_btn = 1'b1;
    cyc();
    bus.stop_btn = 1'b0;
    chk("play->rec rec_len", 32'(bus.rec_len), 2);

    // play restart, then reset mid-PLAY
    bus.play_btn = 1'b1;
    cyc();
    bus.play_btn = 1'b0;
    tick_once();
    chk("replay raddr 1", 32'(bus.raddr), 1);
    bus.play_btn = 1'b1;
    cyc();
    bus.play_btn = 1'b0;
    chk("replay raddr 0", 32'(bus.raddr), 0);
    tick_once();
    chk("replay raddr again", 32'(bus.raddr), 1);
    chk("replay state", 32'(bus.state), 2);
    rst = 1'b1;
    cyc();
    chk_reset_vals("rst mid-play");
    rst = 1'b0;
    cyc();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/rec_play_ctrl.md
Name: rec_play_ctrl

Overview:
Sequencer for the audio sample buffer between the I2S/PDM microphone front end and the headphone DAC outputs.
- Turns record/play/stop requests into buffer write-enable and read/write address sequences, paced by the microphone's sample-ready strobe.
- Remembers the recorded length.
- Drives the select line that chooses live microphone audio or buffered audio for the outputs.

Parameters:
ADDR_W, 16, buffer address width; capacity DEPTH = 2**ADDR_W samples
MIN_LEN, 1, minimum recorded samples before playback is permitted

Ports:
clk  in  1  system clock (same domain as buffer and mic deserialiser)
rst  in  1  synchronous, active-high reset
sample_tick  in  1  one-cycle strobe, new mic sample valid this cycle
rec_btn  in  1  record request level (already synchronised)
play_btn  in  1  play request level (already synchronised)
stop_btn  in  1  stop request level (already synchronised)
we  out  1  buffer write enable
waddr  out  ADDR_W  buffer write address
raddr  out  ADDR_W  buffer read address
buff_sel  out  1  1 = outputs take buffer data, 0 = live mic
state  out  2  00 IDLE, 01 RECORD, 10 PLAY, 11 unused
rec_len  out  ADDR_W+1  samples held from the last completed recording
full  out  1  pulse, one cycle, when recording stops on capacity

Behaviour:
Reset:
- Outputs on reset: state IDLE, we 0, waddr 0, raddr 0, buff_sel 0, rec_len 0, full 0.
- Edge-detect registers cleared on reset.
- Reset mid-RECORD or mid-PLAY aborts immediately; a partial recording is discarded (rec_len 0).

Request detection:
- Each *_btn is rising-edge detected internally (registered previous value).
- A held button does not retrigger.
- Same-cycle request priority: stop > rec > play.

IDLE:
- rec edge -> RECORD: waddr <= 0.
- play edge with rec_len >= MIN_LEN -> PLAY: raddr <= 0.
- play edge with rec_len < MIN_LEN is ignored.

RECORD:
- we = sample_tick (combinational, same cycle); waddr holds the current slot.
- The cycle after a write, waddr increments.
- Stop edge -> IDLE; rec_len <= number of samples written (waddr, counting a write in the same cycle).
- Write to address DEPTH-1 -> IDLE next cycle; rec_len <= DEPTH; full pulses for 1 cycle; waddr wraps to 0 and has no further effect.
- Rec edge while RECORD restarts: waddr <= 0, and no write occurs that cycle even if sample_tick is high.
- Play edge is ignored.

PLAY:
- buff_sel = 1 (registered, asserted the cycle PLAY is entered).
- raddr advances by 1 on each sample_tick; buffer read latency is 1 cycle and is absorbed by the tick spacing.
- On the sample_tick where raddr = rec_len-1 -> IDLE, raddr <= 0, buff_sel <= 0.
- Stop edge -> IDLE immediately.
- Rec edge -> RECORD (stop playback, start new recording).
- Play edge restarts: raddr <= 0.

Invariants:
- we is never asserted outside RECORD.
- waddr and raddr never exceed DEPTH-1.
- rec_len is updated only on RECORD exit by stop or full.

Optional Feature:
LOOP_PLAY_EN:
- Defined: in PLAY, the end-of-recording tick wraps raddr to 0 and stays in PLAY; only a stop or rec edge leaves PLAY.
- Undefined: single-shot playback as above.

Test Plan:
- Reset then idle with ticks every 12 cycles -> we never 1, state 00, buff_sel 0, rec_len 0.
- rec edge, 5 sample_ticks, stop edge -> we pulses at waddr 0..4, state back 00, rec_len 5.
- Play after that recording (LOOP_PLAY_EN off) -> buff_sel 1, raddr steps 0,1,2,3,4 on ticks; after the 5th tick state 00, buff_sel 0, raddr 0.
- ADDR_W=3, rec with 10 ticks -> 8 writes at addresses 0..7, full pulses once, rec_len 8, ticks 9-10 produce no we.
- Same-cycle stop+rec+play edges in IDLE -> stays IDLE. In RECORD, rec edge coinciding with sample_tick -> no we that cycle, waddr 0.
- LOOP_PLAY_EN defined, rec_len 3, play for 7 ticks -> raddr 0,1,2,0,1,2,0, state stays 10 until stop edge. Separately: rst asserted mid-PLAY -> all outputs at reset values the next cycle.
